scr_wr_ctrl: RTL and testbench

CPU-side write engine for the screen RAM write port. It takes single-cycle register writes that are already synchronous to the pixel-fabric clock. It keeps a screen cursor address with auto-increment and wrap, and drives the RAM write port as registered outputs one cycle after each accepted write. It also runs a hardware fill/clear state machine that writes a fixed value to the whole screen while reporting busy.

---
 rtl/scr_wr_ctrl.sv | 169 ++++++++++++++++
 tb/tb_scr_wr_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/scr_wr_ctrl.sv
// Screen RAM write engine: register-driven cursor writes with auto-increment/wrap,
// plus a hardware fill state machine that sweeps the whole screen with one value.
module scr_wr_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SCR_WORDS = 4800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_we,
  input  logic [3:0]        reg_sel,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy
);

  localparam logic [3:0] SEL_DATA    = 4'd1;
  localparam logic [3:0] SEL_ADDR_LO = 4'd3;
  localparam logic [3:0] SEL_ADDR_HI = 4'd4;
  localparam logic [3:0] SEL_CTRL    = 4'd5;
  localparam logic [3:0] SEL_FILL    = 4'd6;
  localparam logic [3:0] SEL_CMD     = 4'd7;
  localparam logic [3:0] SEL_STATUS  = 4'd8;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCR_WORDS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   fill_val_q, fill_val_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic                overrun_q, overrun_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic                wr_data, wr_lo, wr_hi, wr_ctrl, wr_fill, wr_cmd;
  logic                cmd_start, cmd_clr, cmd_abort, fill_last;
  logic [ADDR_W-1:0]   cursor_inc;

  assign wr_data   = reg_we && (reg_sel == SEL_DATA);
  assign wr_lo     = reg_we && (reg_sel == SEL_ADDR_LO);
  assign wr_hi     = reg_we && (reg_sel == SEL_ADDR_HI);
  assign wr_ctrl   = reg_we && (reg_sel == SEL_CTRL);
  assign wr_fill   = reg_we && (reg_sel == SEL_FILL);
  assign wr_cmd    = reg_we && (reg_sel == SEL_CMD);
  assign cmd_start = wr_cmd && reg_wdata[0];
  assign cmd_clr   = wr_cmd && reg_wdata[1];
  assign cmd_abort = wr_cmd && reg_wdata[2];
  assign fill_last = (cnt_q == LAST_ADDR);

  // wrap=1 folds the last screen location back to 0; otherwise natural rollover
  assign cursor_inc = (ctrl_q[1] && (cursor_q == LAST_ADDR)) ? '0 : cursor_q + ADDR_W'(1);

  // State register and all datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cursor_q    <= '0;
      ctrl_q      <= 2'b11;
      fill_val_q  <= DATA_W'(8'h20);
      fill_data_q <= '0;
      overrun_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cursor_q    <= cursor_d;
      ctrl_q      <= ctrl_d;
      fill_val_q  <= fill_val_d;
      fill_data_q <= fill_data_d;
      overrun_q   <= overrun_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (fill_last || cmd_abort) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and register-file next values
  always_comb begin
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cursor_d    = cursor_q;
    ctrl_d      = ctrl_q;
    fill_val_d  = fill_val_q;
    fill_data_d = fill_data_q;
    overrun_d   = overrun_q;

    if (wr_lo)   cursor_d[7:0]  = reg_wdata[7:0];
    if (wr_hi)   cursor_d[15:8] = reg_wdata[7:0];
    if (wr_ctrl) ctrl_d         = reg_wdata[1:0];
    if (wr_fill) fill_val_d     = reg_wdata;
    if (cmd_clr) overrun_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_data) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = cursor_q;
          ram_wdata_d = reg_wdata;
          if (ctrl_q[0]) cursor_d = cursor_inc;
        end
        if (cmd_start) fill_data_d = fill_val_q;
      end
      S_FILL: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = cnt_q;
        ram_wdata_d = fill_data_q;
        if (wr_data)   overrun_d = 1'b1;
        // a completed sweep homes the cursor even over a concurrent address write
        if (fill_last) cursor_d  = '0;
      end
      default: ;
    endcase
  end

  // Combinational read-back
  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      SEL_ADDR_LO: reg_rdata = DATA_W'(cursor_q[7:0]);
      SEL_ADDR_HI: reg_rdata = DATA_W'(cursor_q[15:8]);
      SEL_CTRL:    reg_rdata = DATA_W'(ctrl_q);
      SEL_FILL:    reg_rdata = fill_val_q;
      SEL_STATUS:  reg_rdata = DATA_W'({overrun_q, busy});
      default:     reg_rdata = '0;
    endcase
  end

  assign busy      = (state_q == S_FILL);
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_scr_wr_ctrl.sv
// Directed bench for scr_wr_ctrl: cursor writes, wrap/no-wrap, fill, overrun, abort, reset.
module tb_scr_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_we;
  logic [3:0]  reg_sel;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  scr_wr_ctrl #(.ADDR_W(16), .DATA_W(8), .SCR_WORDS(4800)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_we    (reg_we),
    .reg_sel   (reg_sel),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One register write sampled by exactly one rising edge; returns just after that edge
  task automatic wr(input logic [3:0] s, input logic [7:0] d);
    @(negedge clk);
    reg_we = 1'b1; reg_sel = s; reg_wdata = d;
    @(posedge clk);
    #1;
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] s, output logic [7:0] v);
    reg_sel = s;
    #1;
    v = reg_rdata;
  endtask

  // Observe a fill started by the previous edge; optionally inject one write at sample inj_c
  task automatic fill_run(input int inj_c, input logic [3:0] inj_sel, input logic [7:0] inj_data,
                          input logic [7:0] exp_data, output int busy_cnt, output int we_cnt,
                          output int bad, output int last_addr, output logic [7:0] mid_status,
                          output bit done);
    busy_cnt = 0; we_cnt = 0; bad = 0; last_addr = -1; mid_status = 8'hxx; done = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      logic b, w;
      b = busy; w = ram_we;
      if (b) busy_cnt++;
      if (w) begin
        if (ram_addr !== 16'(we_cnt) || ram_wdata !== exp_data) bad++;
        last_addr = int'(ram_addr);
        we_cnt++;
      end
      if (c == inj_c) begin
        reg_we = 1'b1; reg_sel = inj_sel; reg_wdata = inj_data;
      end else begin
        reg_we = 1'b0; reg_sel = 4'd8;
      end
      #1;
      if (c == inj_c + 1) mid_status = reg_rdata;
      if (!b && !w) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    reg_we = 1'b0;
  endtask

  logic [7:0] v;
  logic [7:0] ms;
  int bc, wc, bad, la;
  bit done;

  initial begin
    rst_n = 1'b0; reg_we = 1'b0; reg_sel = 4'd0; reg_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 16'h0000);
    chk("rst_ram_wdata", ram_wdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rd(4'd5, v); chk("rst_ctrl", v, 8'h03);
    rd(4'd6, v); chk("rst_fill_val", v, 8'h20);
    rd(4'd8, v); chk("rst_status", v, 8'h00);
    rd(4'd3, v); chk("rst_cursor_lo", v, 8'h00);
    @(negedge clk); rst_n = 1'b1;

    // back-to-back DATA writes with auto-increment
    wr(4'd3, 8'h10); wr(4'd4, 8'h00);
    wr(4'd1, 8'h41);
    chk("b2b_we0", ram_we, 1'b1);
    chk("b2b_addr0", ram_addr, 16'h0010);
    chk("b2b_data0", ram_wdata, 8'h41);
    wr(4'd1, 8'h42);
    chk("b2b_we1", ram_we, 1'b1);
    chk("b2b_addr1", ram_addr, 16'h0011);
    chk("b2b_data1", ram_wdata, 8'h42);
    @(posedge clk); #1;
    chk("b2b_we_idle", ram_we, 1'b0);
    rd(4'd3, v); chk("b2b_cursor_lo", v, 8'h12);

    // wrap at last screen location
    wr(4'd3, 8'hBF); wr(4'd4, 8'h12); wr(4'd5, 8'h03);
    wr(4'd1, 8'h55);
    chk("wrap_addr", ram_addr, 16'h12BF);
    chk("wrap_data", ram_wdata, 8'h55);
    rd(4'd3, v); chk("wrap_cur_lo", v, 8'h00);
    rd(4'd4, v); chk("wrap_cur_hi", v, 8'h00);

    // no wrap: passes the screen end
    wr(4'd3, 8'hBF); wr(4'd4, 8'h12); wr(4'd5, 8'h01);
    wr(4'd1, 8'h55);
    chk("nowrap_addr", ram_addr, 16'h12BF);
    rd(4'd3, v); chk("nowrap_cur_lo", v, 8'hC0);
    rd(4'd4, v); chk("nowrap_cur_hi", v, 8'h12);

    // no wrap: 16-bit rollover
    wr(4'd3, 8'hFF); wr(4'd4, 8'hFF);
    wr(4'd1, 8'h66);
    chk("roll_addr", ram_addr, 16'hFFFF);
    rd(4'd3, v); chk("roll_cur_lo", v, 8'h00);
    rd(4'd4, v); chk("roll_cur_hi", v, 8'h00);

    // autoinc off: cursor holds
    wr(4'd5, 8'h00); wr(4'd3, 8'h20); wr(4'd4, 8'h00);
    wr(4'd1, 8'hA1); chk("hold_addr0", ram_addr, 16'h0020);
    wr(4'd1, 8'hA2); chk("hold_addr1", ram_addr, 16'h0020);
    wr(4'd1, 8'hA3); chk("hold_addr2", ram_addr, 16'h0020);
    chk("hold_data2", ram_wdata, 8'hA3);
    rd(4'd3, v); chk("hold_cur_lo", v, 8'h20);

    // full-screen fill
    wr(4'd6, 8'h20);
    wr(4'd7, 8'h01);
    chk("fill1_busy_start", busy, 1'b1);
    fill_run(-10, 4'd0, 8'h00, 8'h20, bc, wc, bad, la, ms, done);
    chk("fill1_done", done, 1'b1);
    chk("fill1_busy_cycles", bc, 4800);
    chk("fill1_we_cycles", wc, 4800);
    chk("fill1_order_bad", bad, 0);
    rd(4'd8, v); chk("fill1_status", v, 8'h00);
    rd(4'd3, v); chk("fill1_cur_lo", v, 8'h00);
    rd(4'd4, v); chk("fill1_cur_hi", v, 8'h00);

    // DATA write during a fill is dropped and flags overrun; fill value latched at start
    wr(4'd6, 8'h5A);
    wr(4'd7, 8'h01);
    fill_run(100, 4'd1, 8'h99, 8'h5A, bc, wc, bad, la, ms, done);
    chk("fill2_done", done, 1'b1);
    chk("fill2_we_cycles", wc, 4800);
    chk("fill2_order_bad", bad, 0);
    chk("fill2_mid_status", ms, 8'h03);
    rd(4'd8, v); chk("fill2_status", v, 8'h02);
    wr(4'd7, 8'h02);
    rd(4'd8, v); chk("fill2_clr_status", v, 8'h00);

    // abort at cnt=50 leaves the cursor alone
    wr(4'd3, 8'h23); wr(4'd4, 8'h01);
    wr(4'd7, 8'h01);
    fill_run(50, 4'd7, 8'h04, 8'h5A, bc, wc, bad, la, ms, done);
    chk("abort_done", done, 1'b1);
    chk("abort_we_cycles", wc, 51);
    chk("abort_last_addr", la, 50);
    chk("abort_busy_cycles", bc, 51);
    chk("abort_order_bad", bad, 0);
    rd(4'd3, v); chk("abort_cur_lo", v, 8'h23);
    rd(4'd4, v); chk("abort_cur_hi", v, 8'h01);

    // async reset in the middle of a fill
    wr(4'd5, 8'h00); wr(4'd6, 8'h77);
    wr(4'd7, 8'h01);
    repeat (2000) @(posedge clk);
    #1;
    chk("prerst_we", ram_we, 1'b1);
    chk("prerst_addr", ram_addr, 16'd1999);
    rst_n = 1'b0;
    #1;
    chk("rst2_we", ram_we, 1'b0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_addr", ram_addr, 16'h0000);
    chk("rst2_wdata", ram_wdata, 8'h00);
    rd(4'd5, v); chk("rst2_ctrl", v, 8'h03);
    rd(4'd6, v); chk("rst2_fill_val", v, 8'h20);
    rd(4'd8, v); chk("rst2_status", v, 8'h00);
    rd(4'd3, v); chk("rst2_cur_lo", v, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst2_we_after", ram_we, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
